// File: rtl/fp_exp_align_if.sv
// rtl/fp_exp_align_if.sv - operand/result handshake bundle for fp_exp_align
//
// Purpose: groups the input operand channel (in_valid/in_ready, a_*, b_*) and
// the aligned result channel (out_valid/out_ready, big_*, small_sig, exp_diff,
// swap, sat, sat_count) of the exponent-align stage.
// Modports:
//   master - operand producer / result consumer (drives in_*, a_*, b_*, out_ready)
//   slave  - the align stage itself
interface fp_exp_align_if #(
    parameter int EXP_W = 11,
    parameter int SIG_W = 53,
    parameter int CNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [EXP_W-1:0]   a_exp;
    logic [SIG_W-1:0]   a_sig;
    logic [EXP_W-1:0]   b_exp;
    logic [SIG_W-1:0]   b_sig;
    logic               out_valid;
    logic               out_ready;
    logic [EXP_W-1:0]   big_exp;
    logic [SIG_W+2:0]   big_sig;
    logic [SIG_W+2:0]   small_sig;
    logic [EXP_W-1:0]   exp_diff;
    logic               swap;
    logic               sat;
    logic [CNT_W-1:0]   sat_count;

    modport master (
        output in_valid, a_exp, a_sig, b_exp, b_sig, out_ready,
        input  in_ready, out_valid, big_exp, big_sig, small_sig,
               exp_diff, swap, sat, sat_count
    );

    modport slave (
        input  in_valid, a_exp, a_sig, b_exp, b_sig, out_ready,
        output in_ready, out_valid, big_exp, big_sig, small_sig,
               exp_diff, swap, sat, sat_count
    );
endinterface

// File: rtl/fp_exp_align.sv
// rtl/fp_exp_align.sv - 2-stage exponent compare and significand align stage
//
// Purpose: stage 1 picks the operand with the larger exponent and registers
// |a_exp - b_exp|; stage 2 right-shifts the smaller significand (extended by
// three G/R/S bits) with sticky collection, saturating when the shift reaches
// the full extended width.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   io    - fp_exp_align_if.slave (operand channel in, aligned result out)
// Optional feature macro: FP_ALIGN_SATCNT_EN (saturated-result counter on
// io.sat_count; tied to 0 when undefined).
module fp_exp_align #(
    parameter int EXP_W = 11,
    parameter int SIG_W = 53,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    fp_exp_align_if.slave io
);
    localparam int EW = SIG_W + 3;
    // Compare width wide enough for both the shift amount and EW.
    localparam int CW = (EXP_W > 32) ? EXP_W : 32;

    // Stage 1 state
    logic             s1_v_q, s1_v_d;
    logic [EXP_W-1:0] s1_big_exp_q, s1_big_exp_d;
    logic [SIG_W-1:0] s1_big_sig_q, s1_big_sig_d;
    logic [SIG_W-1:0] s1_small_sig_q, s1_small_sig_d;
    logic [EXP_W-1:0] s1_diff_q, s1_diff_d;
    logic             s1_swap_q, s1_swap_d;

    // Stage 2 state (drives the outputs directly)
    logic             s2_v_q, s2_v_d;
    logic [EXP_W-1:0] big_exp_q, big_exp_d;
    logic [EW-1:0]    big_sig_q, big_sig_d;
    logic [EW-1:0]    small_sig_q, small_sig_d;
    logic [EXP_W-1:0] exp_diff_q, exp_diff_d;
    logic             swap_q, swap_d;
    logic             sat_q, sat_d;

    logic             s1_adv;
    logic             in_fire;
    logic [EXP_W:0]   d_raw;
    logic             a_lt_b;
    logic [EW-1:0]    ext;
    logic [EW-1:0]    shifted;
    logic [EW-1:0]    lost_mask;
    logic             sticky;
    logic [CW-1:0]    diff_cmp;

    assign s1_adv      = s1_v_q && (!s2_v_q || io.out_ready);
    assign io.in_ready = !s1_v_q || s1_adv;
    assign in_fire     = io.in_valid && io.in_ready;

    assign io.out_valid = s2_v_q;
    assign io.big_exp   = big_exp_q;
    assign io.big_sig   = big_sig_q;
    assign io.small_sig = small_sig_q;
    assign io.exp_diff  = exp_diff_q;
    assign io.swap      = swap_q;
    assign io.sat       = sat_q;

    // Borrow out of the (EXP_W+1)-bit difference means a_exp < b_exp.
    assign d_raw  = {1'b0, io.a_exp} - {1'b0, io.b_exp};
    assign a_lt_b = d_raw[EXP_W];

    // Bits pushed below bit 0 by the shift feed the sticky bit.
    assign ext       = {s1_small_sig_q, 3'b000};
    assign shifted   = ext >> s1_diff_q;
    assign lost_mask = ~({EW{1'b1}} << s1_diff_q);
    assign sticky    = |(ext & lost_mask);
    assign diff_cmp  = CW'(s1_diff_q);

    always_comb begin
        s1_v_d         = s1_v_q;
        s1_big_exp_d   = s1_big_exp_q;
        s1_big_sig_d   = s1_big_sig_q;
        s1_small_sig_d = s1_small_sig_q;
        s1_diff_d      = s1_diff_q;
        s1_swap_d      = s1_swap_q;
        s2_v_d         = s2_v_q;
        big_exp_d      = big_exp_q;
        big_sig_d      = big_sig_q;
        small_sig_d    = small_sig_q;
        exp_diff_d     = exp_diff_q;
        swap_d         = swap_q;
        sat_d          = sat_q;

        if (in_fire) begin
            s1_v_d    = 1'b1;
            s1_swap_d = a_lt_b;
            if (a_lt_b) begin
                s1_big_exp_d   = io.b_exp;
                s1_big_sig_d   = io.b_sig;
                s1_small_sig_d = io.a_sig;
                s1_diff_d      = io.b_exp - io.a_exp;
            end else begin
                s1_big_exp_d   = io.a_exp;
                s1_big_sig_d   = io.a_sig;
                s1_small_sig_d = io.b_sig;
                s1_diff_d      = io.a_exp - io.b_exp;
            end
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end

        if (s1_adv) begin
            s2_v_d     = 1'b1;
            big_exp_d  = s1_big_exp_q;
            big_sig_d  = {s1_big_sig_q, 3'b000};
            exp_diff_d = s1_diff_q;
            swap_d     = s1_swap_q;
            if (diff_cmp < CW'(EW)) begin
                small_sig_d = {shifted[EW-1:1], shifted[0] | sticky};
                sat_d       = 1'b0;
            end else begin
                // Everything shifted out: only the sticky bit survives.
                small_sig_d = {{(EW-1){1'b0}}, |ext};
                sat_d       = 1'b1;
            end
        end else if (io.out_ready) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q         <= 1'b0;
            s1_big_exp_q   <= '0;
            s1_big_sig_q   <= '0;
            s1_small_sig_q <= '0;
            s1_diff_q      <= '0;
            s1_swap_q      <= 1'b0;
            s2_v_q         <= 1'b0;
            big_exp_q      <= '0;
            big_sig_q      <= '0;
            small_sig_q    <= '0;
            exp_diff_q     <= '0;
            swap_q         <= 1'b0;
            sat_q          <= 1'b0;
        end else begin
            s1_v_q         <= s1_v_d;
            s1_big_exp_q   <= s1_big_exp_d;
            s1_big_sig_q   <= s1_big_sig_d;
            s1_small_sig_q <= s1_small_sig_d;
            s1_diff_q      <= s1_diff_d;
            s1_swap_q      <= s1_swap_d;
            s2_v_q         <= s2_v_d;
            big_exp_q      <= big_exp_d;
            big_sig_q      <= big_sig_d;
            small_sig_q    <= small_sig_d;
            exp_diff_q     <= exp_diff_d;
            swap_q         <= swap_d;
            sat_q          <= sat_d;
        end
    end

`ifdef FP_ALIGN_SATCNT_EN
    logic [CNT_W-1:0] sat_count_q, sat_count_d;

    always_comb begin
        sat_count_d = sat_count_q;
        // Counts saturated results as they leave; sticks at all-ones.
        if (s2_v_q && io.out_ready && sat_q && (sat_count_q != {CNT_W{1'b1}}))
            sat_count_d = sat_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) sat_count_q <= '0;
        else       sat_count_q <= sat_count_d;
    end

    assign io.sat_count = sat_count_q;
`else
    assign io.sat_count = '0;
`endif
endmodule

// File: tb/tb_fp_exp_align.sv
// tb/tb_fp_exp_align.sv - directed self-checking bench for fp_exp_align
module tb_fp_exp_align;
    localparam int EXP_W = 11;
    localparam int SIG_W = 53;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    fp_exp_align_if #(.EXP_W(EXP_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) io ();

    fp_exp_align #(.EXP_W(EXP_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

`ifdef FP_ALIGN_SATCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    localparam logic [SIG_W-1:0] S1 = 53'h10000000000001;
    localparam logic [SIG_W-1:0] SB = 53'h1ABCDEF0123456;
    localparam logic [SIG_W-1:0] M  = 53'h10000000000000;
    localparam logic [55:0]      SB_EXT = 56'hD5E6F78091A2B0;
    localparam logic [55:0]      TOP    = 56'h80000000000000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_in(input logic [EXP_W-1:0] ae, input logic [SIG_W-1:0] as_,
                          input logic [EXP_W-1:0] be, input logic [SIG_W-1:0] bs);
        io.a_exp = ae;
        io.a_sig = as_;
        io.b_exp = be;
        io.b_sig = bs;
        io.in_valid = 1'b1;
    endtask

    // One transfer with out_ready high; result is visible on return.
    task automatic run_one(input string tag, input logic [EXP_W-1:0] ae, input logic [SIG_W-1:0] as_,
                           input logic [EXP_W-1:0] be, input logic [SIG_W-1:0] bs);
        set_in(ae, as_, be, bs);
        tick();
        check({tag, ".lat1_valid"}, 64'(io.out_valid), 64'd0);
        io.in_valid = 1'b0;
        tick();
        check({tag, ".out_valid"}, 64'(io.out_valid), 64'd1);
    endtask

    initial begin
        reset        = 1'b1;
        io.in_valid  = 1'b0;
        io.a_exp     = '0;
        io.a_sig     = '0;
        io.b_exp     = '0;
        io.b_sig     = '0;
        io.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst.out_valid", 64'(io.out_valid), 64'd0);
        check("rst.in_ready",  64'(io.in_ready),  64'd1);
        check("rst.big_exp",   64'(io.big_exp),   64'd0);
        check("rst.small_sig", 64'(io.small_sig), 64'd0);
        check("rst.sat_count", 64'(io.sat_count), 64'd0);

        run_one("t1", 11'd200, S1, 11'd180, S1);
        check("t1.exp_diff",  64'(io.exp_diff),  64'd20);
        check("t1.swap",      64'(io.swap),      64'd0);
        check("t1.sat",       64'(io.sat),       64'd0);
        check("t1.big_exp",   64'(io.big_exp),   64'd200);
        check("t1.big_sig",   64'(io.big_sig),   64'(56'h80000000000008));
        check("t1.small_sig", 64'(io.small_sig), 64'(56'h00000800000001));

        run_one("t2", 11'd127, M, 11'd200, SB);
        check("t2.swap",      64'(io.swap),      64'd1);
        check("t2.exp_diff",  64'(io.exp_diff),  64'd73);
        check("t2.big_exp",   64'(io.big_exp),   64'd200);
        check("t2.big_sig",   64'(io.big_sig),   64'(SB_EXT));
        check("t2.sat",       64'(io.sat),       64'd1);
        check("t2.small_sig", 64'(io.small_sig), 64'd1);

        run_one("t3", 11'd200, SB, 11'd200, SB);
        check("t3.exp_diff",  64'(io.exp_diff),  64'd0);
        check("t3.swap",      64'(io.swap),      64'd0);
        check("t3.sat",       64'(io.sat),       64'd0);
        check("t3.small_sig", 64'(io.small_sig), 64'(SB_EXT));
        check("t3.sat_count", 64'(io.sat_count), CNT_ON ? 64'd1 : 64'd0);

        run_one("t4", 11'd30, SB, 11'd240, SB);
        check("t4.exp_diff",  64'(io.exp_diff),  64'd210);
        check("t4.swap",      64'(io.swap),      64'd1);
        check("t4.sat",       64'(io.sat),       64'd1);
        check("t4.big_exp",   64'(io.big_exp),   64'd240);

        run_one("d55", 11'd255, SB, 11'd200, M);
        check("d55.sat",       64'(io.sat),       64'd0);
        check("d55.small_sig", 64'(io.small_sig), 64'd1);
        check("d55.exp_diff",  64'(io.exp_diff),  64'd55);

        run_one("d54", 11'd254, SB, 11'd200, M);
        check("d54.sat",       64'(io.sat),       64'd0);
        check("d54.small_sig", 64'(io.small_sig), 64'd2);

        run_one("d56", 11'd256, SB, 11'd200, M);
        check("d56.sat",       64'(io.sat),       64'd1);
        check("d56.small_sig", 64'(io.small_sig), 64'd1);

        run_one("zero", 11'd205, SB, 11'd200, '0);
        check("zero.sat",       64'(io.sat),       64'd0);
        check("zero.small_sig", 64'(io.small_sig), 64'd0);
        check("zero.exp_diff",  64'(io.exp_diff),  64'd5);

        run_one("max", 11'd2047, SB, 11'd0, SB);
        check("max.exp_diff",  64'(io.exp_diff),  64'd2047);
        check("max.sat",       64'(io.sat),       64'd1);
        check("max.small_sig", 64'(io.small_sig), 64'd1);
        check("max.swap",      64'(io.swap),      64'd0);

        tick();
        check("drain.out_valid", 64'(io.out_valid), 64'd0);
        check("drain.sat_count", 64'(io.sat_count), CNT_ON ? 64'd4 : 64'd0);

        // Backpressure: fill both stages with out_ready low.
        io.out_ready = 1'b0;
        set_in(11'd101, M, 11'd100, M);
        tick();
        check("bp.in_ready0",  64'(io.in_ready),  64'd1);
        check("bp.out_valid0", 64'(io.out_valid), 64'd0);
        set_in(11'd102, M, 11'd100, M);
        tick();
        check("bp.out_valid1", 64'(io.out_valid), 64'd1);
        check("bp.in_ready1",  64'(io.in_ready),  64'd0);
        set_in(11'd103, M, 11'd100, M);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp.hold_valid", 64'(io.out_valid), 64'd1);
            check("bp.hold_ready", 64'(io.in_ready),  64'd0);
            check("bp.hold_diff",  64'(io.exp_diff),  64'd1);
            check("bp.hold_small", 64'(io.small_sig), 64'(TOP >> 1));
        end
        io.out_ready = 1'b1;
        #1;
        check("bp.in_ready_rel", 64'(io.in_ready), 64'd1);
        check("bp.r0_diff",      64'(io.exp_diff), 64'd1);
        tick();
        set_in(11'd104, M, 11'd100, M);
        check("bp.r1_valid", 64'(io.out_valid), 64'd1);
        check("bp.r1_diff",  64'(io.exp_diff),  64'd2);
        check("bp.r1_small", 64'(io.small_sig), 64'(TOP >> 2));
        tick();
        io.in_valid = 1'b0;
        check("bp.r2_valid", 64'(io.out_valid), 64'd1);
        check("bp.r2_diff",  64'(io.exp_diff),  64'd3);
        tick();
        check("bp.r3_valid", 64'(io.out_valid), 64'd1);
        check("bp.r3_diff",  64'(io.exp_diff),  64'd4);
        check("bp.r3_small", 64'(io.small_sig), 64'(TOP >> 4));
        tick();
        check("bp.empty", 64'(io.out_valid), 64'd0);

        // Reset with a full pipe.
        io.out_ready = 1'b0;
        set_in(11'd127, M, 11'd200, SB);
        tick();
        tick();
        check("mrst.full_valid", 64'(io.out_valid), 64'd1);
        check("mrst.full_ready", 64'(io.in_ready),  64'd0);
        io.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst.out_valid", 64'(io.out_valid), 64'd0);
        check("mrst.in_ready",  64'(io.in_ready),  64'd1);
        check("mrst.sat_count", 64'(io.sat_count), 64'd0);
        check("mrst.big_exp",   64'(io.big_exp),   64'd0);
        check("mrst.small_sig", 64'(io.small_sig), 64'd0);
        check("mrst.exp_diff",  64'(io.exp_diff),  64'd0);
        check("mrst.swap",      64'(io.swap),      64'd0);
        check("mrst.sat",       64'(io.sat),       64'd0);

        io.out_ready = 1'b1;
        run_one("post", 11'd200, S1, 11'd180, S1);
        check("post.exp_diff",  64'(io.exp_diff),  64'd20);
        check("post.small_sig", 64'(io.small_sig), 64'(56'h00000800000001));
        check("post.big_exp",   64'(io.big_exp),   64'd200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
